// File: rtl/sqrl_uart_recv_pkg.sv
// Shared definitions for the comm-link UART: bit-period derivation and receiver states.
// The transmitter imports the same helper so both ends use an identical bit period.
package sqrl_uart_recv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Clocks per bit minus one; the counters compare against this terminal value.
    function automatic logic [15:0] calc_baud_delay(input int unsigned clk_hz,
                                                    input int unsigned baud);
        return 16'(clk_hz / baud - 1);
    endfunction

endpackage

// File: rtl/sqrl_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL lets the caller preload the idle level of the line being synchronised.
module sqrl_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sqrl_uart_recv.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing-error strobe,
// one-cycle byte strobe for the downstream command parser.
module sqrl_uart_recv
    import sqrl_uart_recv_pkg::*;
#(
    parameter int unsigned comm_clk_frequency = 100000000,
    parameter int unsigned baud_rate          = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       rx_new_byte,
    output logic [7:0] rx_byte,
    output logic       rx_framing_error,
    output logic       rx_busy
);

    localparam logic [15:0] BAUD_DELAY = calc_baud_delay(comm_clk_frequency, baud_rate);
    localparam logic [15:0] HALF_DELAY = BAUD_DELAY >> 1;

    logic       rx_s;
    rx_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       new_byte_q, new_byte_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] fill_q, fill_d;
    logic       armed_q, armed_d;
    logic       data_tick;

    sqrl_sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d_i (uart_rx),
        .q_o (rx_s)
    );

    assign data_tick = (state_q == ST_DATA) && (cnt_q == BAUD_DELAY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            new_byte_q  <= 1'b0;
            frame_err_q <= 1'b0;
            fill_q      <= '0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            new_byte_q  <= new_byte_d;
            frame_err_q <= frame_err_d;
            fill_q      <= fill_d;
            armed_q     <= armed_d;
        end
    end

    // A start is accepted only after a genuine high line has been seen since reset,
    // so a reset landing inside a frame never turns its remaining low bits into a start.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (armed_q && !rx_s) state_d = ST_START;
            ST_START: if (cnt_q == HALF_DELAY) state_d = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (data_tick && bit_idx_q == 3'd7) state_d = ST_STOP;
            ST_STOP:  if (cnt_q == BAUD_DELAY) state_d = rx_s ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rx_s) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q + 16'd1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        new_byte_d  = 1'b0;
        frame_err_d = 1'b0;
        fill_d      = {fill_q[0], 1'b1};
        armed_d     = armed_q | (fill_q[1] & rx_s);

        if (state_q == ST_IDLE || state_d != state_q || data_tick) begin
            cnt_d = '0;
        end
        if (state_q == ST_START && state_d == ST_DATA) begin
            bit_idx_d = '0;
        end
        if (data_tick) begin
            shift_d   = {rx_s, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
        end
        if (state_q == ST_STOP && cnt_q == BAUD_DELAY) begin
            if (rx_s) begin
                byte_d     = shift_q;
                new_byte_d = 1'b1;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign rx_new_byte      = new_byte_q;
    assign rx_byte          = byte_q;
    assign rx_framing_error = frame_err_q;
    assign rx_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sqrl_uart_recv.sv
// Directed bench for sqrl_uart_recv at 10 clk/bit: single frame, back-to-back,
// start glitch, framing error with break, mid-frame reset and a 256-byte stream.
module tb_sqrl_uart_recv;

    localparam int BIT_CLKS = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_new_byte;
    logic [7:0] rx_byte;
    logic       rx_framing_error;
    logic       rx_busy;

    int total = 0;
    int bad = 0;
    int new_cnt = 0;
    int err_cnt = 0;
    int busy_cnt = 0;
    int excl_viol = 0;
    logic prev_new = 1'b0;
    logic prev_err = 1'b0;
    logic [7:0] rxq[$];

    sqrl_uart_recv #(
        .comm_clk_frequency (1000000),
        .baud_rate          (100000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .uart_rx          (uart_rx),
        .rx_new_byte      (rx_new_byte),
        .rx_byte          (rx_byte),
        .rx_framing_error (rx_framing_error),
        .rx_busy          (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_new_byte) begin
            new_cnt++;
            rxq.push_back(rx_byte);
        end
        if (rx_framing_error) err_cnt++;
        if (rx_busy) busy_cnt++;
        if ((rx_new_byte && rx_framing_error) || (rx_new_byte && prev_err) ||
            (rx_framing_error && prev_new))
            excl_viol++;
        prev_new = rx_new_byte;
        prev_err = rx_framing_error;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b[k];
            repeat (BIT_CLKS) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle(input int n);
        uart_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n0, e0, base, mism;
        logic [7:0] b81;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_new_byte", rx_new_byte, 0);
        check("reset_framing_error", rx_framing_error, 0);
        check("reset_busy", rx_busy, 0);
        check("reset_byte", rx_byte, 8'h00);
        idle(10);

        // Single frame 0xA5
        n0 = new_cnt; e0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        idle(20);
        check("single_pulses", new_cnt - n0, 1);
        check("single_byte", rx_byte, 8'hA5);
        check("single_queue", rxq[rxq.size()-1], 8'hA5);
        check("single_no_err", err_cnt - e0, 0);
        check("single_busy_low", rx_busy, 0);

        // Back-to-back 0x00 then 0xFF with no gap
        n0 = new_cnt; e0 = err_cnt; base = rxq.size();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(20);
        check("b2b_pulses", new_cnt - n0, 2);
        check("b2b_first", rxq[base], 8'h00);
        check("b2b_second", rxq[base+1], 8'hFF);
        check("b2b_no_err", err_cnt - e0, 0);

        // Start glitch of 2 clk, then 0x3C
        n0 = new_cnt; e0 = err_cnt; busy_cnt = 0;
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(20);
        check("glitch_no_byte", new_cnt - n0, 0);
        check("glitch_no_err", err_cnt - e0, 0);
        check("glitch_busy_len_ok", (busy_cnt >= 1 && busy_cnt <= 6), 1);
        send_byte(8'h3C, 1'b1);
        idle(20);
        check("post_glitch_pulses", new_cnt - n0, 1);
        check("post_glitch_byte", rx_byte, 8'h3C);

        // Framing error: 0x55 with low stop, line held low 50 clk
        n0 = new_cnt; e0 = err_cnt;
        send_byte(8'h55, 1'b0);
        repeat (50) @(negedge clk);
        check("break_busy_high", rx_busy, 1);
        idle(20);
        check("ferr_pulses", err_cnt - e0, 1);
        check("ferr_no_byte", new_cnt - n0, 0);
        check("ferr_byte_kept", rx_byte, 8'h3C);
        check("ferr_busy_low", rx_busy, 0);

        // Reset for 1 clk during data bit 4 of 0x81, then 0x7E
        n0 = new_cnt; e0 = err_cnt;
        b81 = 8'h81;
        uart_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            uart_rx = b81[k];
            if (k == 4) begin
                repeat (5) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                repeat (4) @(negedge clk);
            end else begin
                repeat (BIT_CLKS) @(negedge clk);
            end
        end
        uart_rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("rstmid_no_byte", new_cnt - n0, 0);
        check("rstmid_no_err", err_cnt - e0, 0);
        send_byte(8'h7E, 1'b1);
        idle(20);
        check("rstmid_next_pulses", new_cnt - n0, 1);
        check("rstmid_next_byte", rx_byte, 8'h7E);

        // Stream of 256 sequential bytes, back-to-back
        n0 = new_cnt; e0 = err_cnt; base = rxq.size(); mism = 0;
        for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1);
        idle(30);
        check("stream_pulses", new_cnt - n0, 256);
        check("stream_no_err", err_cnt - e0, 0);
        for (int i = 0; i < 256; i++) begin
            if (base + i >= rxq.size() || rxq[base+i] !== 8'(i)) mism++;
        end
        check("stream_order", mism, 0);

        check("strobe_exclusive", excl_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
